// File: rtl/fp2int_pkg.sv
// Shared types and helpers for the FloPoCo FP->integer result stages.
package fp2int_pkg;

   // FloPoCo exception field encoding
   typedef enum logic [1:0] {
      ZERO   = 2'b00,
      NORMAL = 2'b01,
      INF    = 2'b10,
      NAN    = 2'b11
   } exc_e;

   // Per-operand tag carried alongside the converter latency
   typedef struct packed {
      logic sign;
      exc_e exc;
   } tag_t;

   // Largest positive w-bit two's complement value (low w bits are meaningful)
   function automatic logic [63:0] sat_max(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative w-bit two's complement value (low w bits are meaningful)
   function automatic logic [63:0] sat_min(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/fp2int_res_fifo.sv
// Small circular {data, nv} result FIFO with occupancy count.
module fp2int_res_fifo #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 2,
   localparam int unsigned CntW     = $clog2(Depth + 1),
   localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 nv_i,
   input  logic                 pop_i,
   output logic                 valid_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 nv_o,
   output logic [CntW-1:0]      count_o
);

   logic [DataWidth:0] mem_q [Depth];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               pop_eff;

   // Popping an empty FIFO is silently ignored
   assign pop_eff = pop_i && (count_q != '0);

   // Pointer wrap and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop_eff) rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (push_i && !pop_eff) count_d = count_q + CntW'(1);
      else if (!push_i && pop_eff) count_d = count_q - CntW'(1);
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care while not counted
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= {nv_i, data_i};
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q][DataWidth-1:0] : '0;
   assign nv_o    = valid_o ? mem_q[rd_ptr_q][DataWidth] : 1'b0;
   assign count_o = count_q;

   // Upstream credit must make a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && (count_q == CntW'(Depth))));

endmodule

// File: rtl/fp2int_result_stage.sv
// Result stage behind the fixed-latency FloPoCo FP->int converter:
// tag tracking, saturation, credit-gated issue and buffered output.
module fp2int_result_stage
   import fp2int_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Latency   = 0,
   parameter int unsigned FifoDepth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth+1:0] fp_i,
   input  logic [DataWidth-1:0] conv_int_i,
   input  logic                 conv_ovf_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_nv_o,
   output logic                 nv_sticky_o,
   input  logic                 nv_clear_i
);

   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam logic [DataWidth-1:0] SatMax = DataWidth'(sat_max(DataWidth));
   localparam logic [DataWidth-1:0] SatMin = DataWidth'(sat_min(DataWidth));

   if (Latency > 1) begin : g_bad_latency
      $error("fp2int_result_stage: Latency must be 0 or 1");
   end
   if (FifoDepth < 1) begin : g_bad_depth
      $error("fp2int_result_stage: FifoDepth must be >= 1");
   end
   if (DataWidth != 16 && DataWidth != 32) begin : g_bad_width
      $error("fp2int_result_stage: DataWidth must be 16 or 32");
   end

   logic                 fire;
   tag_t                 tag_in;
   logic                 cap_vld;
   tag_t                 cap_tag;
   logic [31:0]          inflight;
   logic [DataWidth-1:0] res_data;
   logic                 res_nv;
   logic [CntW-1:0]      fifo_cnt;
   logic                 sticky_q, sticky_d;

   assign fire = in_valid_i && in_ready_o;

   // FloPoCo layout: exception field on top, sign bit directly below it
   assign tag_in.exc  = exc_e'(fp_i[DataWidth+1:DataWidth]);
   assign tag_in.sign = fp_i[DataWidth-1];

   if (Latency == 0) begin : g_bypass
      assign cap_vld  = fire;
      assign cap_tag  = tag_in;
      assign inflight = '0;
   end else begin : g_line
      logic [Latency-1:0] vld_pipe_q;
      tag_t               tag_pipe_q [Latency];

      // Valid/tag shift line matching the converter latency
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_pipe_q <= '0;
            for (int i = 0; i < Latency; i++) tag_pipe_q[i] <= '0;
         end else begin
            vld_pipe_q[0] <= fire;
            tag_pipe_q[0] <= tag_in;
            for (int i = 1; i < Latency; i++) begin
               vld_pipe_q[i] <= vld_pipe_q[i-1];
               tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
         end
      end

      assign cap_vld  = vld_pipe_q[Latency-1];
      assign cap_tag  = tag_pipe_q[Latency-1];
      assign inflight = 32'($countones(vld_pipe_q));
   end

   // Saturation: NaN first, then inf/overflow by sign, zero forces 0
   always_comb begin
      res_data = conv_int_i;
      res_nv   = 1'b0;
      if (cap_tag.exc == NAN) begin
         res_data = SatMax;
         res_nv   = 1'b1;
      end else if (cap_tag.exc == INF || conv_ovf_i) begin
         res_data = cap_tag.sign ? SatMin : SatMax;
         res_nv   = 1'b1;
      end else if (cap_tag.exc == ZERO) begin
         res_data = '0;
      end
   end

   fp2int_res_fifo #(
      .DataWidth (DataWidth),
      .Depth     (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cap_vld),
      .data_i  (res_data),
      .nv_i    (res_nv),
      .pop_i   (out_ready_i),
      .valid_o (out_valid_o),
      .data_o  (out_data_o),
      .nv_o    (out_nv_o),
      .count_o (fifo_cnt)
   );

   // Credit: every accepted operand owns a FIFO slot until it is popped
   assign in_ready_o = (32'(fifo_cnt) + inflight) < 32'(FifoDepth);

   // Sticky NV: a new invalid result wins over a same-cycle clear
   always_comb begin
      sticky_d = sticky_q;
      if (nv_clear_i) sticky_d = 1'b0;
      if (cap_vld && res_nv) sticky_d = 1'b1;
   end

   // Sticky NV register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sticky_q <= 1'b0;
      else         sticky_q <= sticky_d;
   end

   assign nv_sticky_o = sticky_q;

endmodule

// File: tb/tb_fp2int_result_stage.sv
// Scoreboard bench for fp2int_result_stage (W=32, Latency=1, FifoDepth=2).
module tb_fp2int_result_stage;

   localparam int W     = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [W-1:0] data;
      logic         nv;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [W+1:0] fp_i = '0;
   logic [W-1:0] conv_int_i = '0;
   logic         conv_ovf_i = 1'b0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [W-1:0] out_data_o;
   logic         out_nv_o;
   logic         nv_sticky_o;
   logic         nv_clear_i = 1'b0;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_issued = 0;
   int   n_popped = 0;
   exp_t exp_q[$];

   logic         pend_vld = 1'b0;
   logic [W-1:0] pend_ci;
   logic         pend_ov;

   fp2int_result_stage #(
      .DataWidth (W),
      .Latency   (1),
      .FifoDepth (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .fp_i        (fp_i),
      .conv_int_i  (conv_int_i),
      .conv_ovf_i  (conv_ovf_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_nv_o    (out_nv_o),
      .nv_sticky_o (nv_sticky_o),
      .nv_clear_i  (nv_clear_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference: RISC-V style FP->int saturation from the operand class
   function automatic exp_t ref_model(logic s, logic [1:0] exc, logic [W-1:0] ci, logic ov);
      longint maxv = (longint'(1) << (W - 1)) - 1;
      longint minv = -(longint'(1) << (W - 1));
      exp_t   r;
      if (exc == 2'b11) begin
         r.data = W'(maxv); r.nv = 1'b1;
      end else if (exc == 2'b10 || ov) begin
         r.data = s ? W'(minv) : W'(maxv); r.nv = 1'b1;
      end else if (exc == 2'b00) begin
         r.data = '0; r.nv = 1'b0;
      end else begin
         r.data = ci; r.nv = 1'b0;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // One cycle: feed the converter result for last cycle's issue, present a new operand
   task automatic drive(input logic v, input logic s, input logic [1:0] exc,
                        input logic [W-1:0] ci, input logic ov, input logic rdy,
                        output logic fired);
      @(negedge clk_i);
      if (pend_vld) begin
         conv_int_i = pend_ci;
         conv_ovf_i = pend_ov;
      end else begin
         conv_int_i = $urandom;
         conv_ovf_i = 1'($urandom);
      end
      pend_vld    = 1'b0;
      in_valid_i  = v;
      fp_i        = {exc, s, 31'($urandom)};
      out_ready_i = rdy;
      check("in_ready_credit", W'(in_ready_o), W'((n_issued - n_popped) < DEPTH));
      fired = v && in_ready_o;
      if (fired) begin
         pend_vld = 1'b1;
         pend_ci  = ci;
         pend_ov  = ov;
         n_issued++;
         exp_q.push_back(ref_model(s, exc, ci, ov));
      end
   endtask

   task automatic idle(input logic rdy);
      logic f;
      drive(1'b0, 1'b0, 2'b01, '0, 1'b0, rdy, f);
   endtask

   // Monitor: compare every handshaken output against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #3;
         if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_output: got data %h nv %b, required no output", out_data_o, out_nv_o);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data_o, e.data);
               check("out_nv", W'(out_nv_o), W'(e.nv));
            end
            n_popped++;
         end
      end
   end

   initial begin
      logic f;
      int   nf;
      int   cyc;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_in_ready", W'(in_ready_o), W'(1));
      check("rst_out_valid", W'(out_valid_o), W'(0));
      check("rst_out_data", out_data_o, '0);
      check("rst_out_nv", W'(out_nv_o), W'(0));
      check("rst_sticky", W'(nv_sticky_o), W'(0));
      rst_ni = 1'b1;

      // +3.0 normal: latency of two cycles to out_valid
      drive(1'b1, 1'b0, 2'b01, 32'd3, 1'b0, 1'b0, f);
      check("lat_fire", W'(f), W'(1));
      idle(1'b0);
      check("lat_valid_t1", W'(out_valid_o), W'(0));
      idle(1'b0);
      check("lat_valid_t2", W'(out_valid_o), W'(1));
      check("lat_data", out_data_o, 32'd3);
      check("lat_nv", W'(out_nv_o), W'(0));
      idle(1'b1);
      idle(1'b1);

      // NaN saturates and sets sticky; clear pulse drops it
      drive(1'b1, 1'b0, 2'b11, $urandom, 1'b0, 1'b1, f);
      idle(1'b1);
      idle(1'b1);
      check("sticky_set", W'(nv_sticky_o), W'(1));
      nv_clear_i = 1'b1;
      idle(1'b1);
      nv_clear_i = 1'b0;
      check("sticky_clear", W'(nv_sticky_o), W'(0));

      // Clear coinciding with an NV push: set wins
      drive(1'b1, 1'b0, 2'b11, $urandom, 1'b0, 1'b1, f);
      idle(1'b1);
      nv_clear_i = 1'b1;
      idle(1'b1);
      nv_clear_i = 1'b0;
      check("sticky_set_wins", W'(nv_sticky_o), W'(1));
      nv_clear_i = 1'b1;
      idle(1'b1);
      nv_clear_i = 1'b0;

      // -inf, then negative normal with converter overflow
      drive(1'b1, 1'b1, 2'b10, $urandom, 1'b0, 1'b1, f);
      drive(1'b1, 1'b1, 2'b01, $urandom, 1'b1, 1'b1, f);
      repeat (4) idle(1'b1);

      // Backpressure: exactly DEPTH issues accepted, then release
      nf = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'($urandom), 2'($urandom), $urandom, 1'b0, 1'b0, f);
         if (f) nf++;
      end
      check("bp_accepted", W'(nf), W'(DEPTH));
      idle(1'b1);
      check("bp_ready_low", W'(in_ready_o), W'(0));
      repeat (4) idle(1'b1);
      check("bp_ready_back", W'(in_ready_o), W'(1));
      check("bp_drained", W'(exp_q.size()), W'(0));

      // Random stream with random consumer backpressure
      nf  = 0;
      cyc = 0;
      while (nf < 100 && cyc < 3000) begin
         logic [1:0] exc;
         exc = 2'($urandom_range(0, 3));
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), exc, $urandom,
               (exc == 2'b01) && ($urandom_range(0, 3) == 0), 1'($urandom), f);
         if (f) nf++;
         cyc++;
      end
      check("rand_issued", W'(nf), W'(100));
      repeat (8) idle(1'b1);
      check("rand_drained", W'(exp_q.size()), W'(0));

      // Reset with one in flight and one buffered
      drive(1'b1, 1'b0, 2'b01, 32'h1111, 1'b0, 1'b0, f);
      drive(1'b1, 1'b0, 2'b01, 32'h2222, 1'b0, 1'b0, f);
      @(posedge clk_i);
      #2;
      check("pre_rst_valid", W'(out_valid_o), W'(1));
      rst_ni     = 1'b0;
      in_valid_i = 1'b0;
      pend_vld   = 1'b0;
      exp_q.delete();
      n_issued = 0;
      n_popped = 0;
      #1;
      check("mid_rst_out_valid", W'(out_valid_o), W'(0));
      check("mid_rst_out_data", out_data_o, '0);
      check("mid_rst_in_ready", W'(in_ready_o), W'(1));
      check("mid_rst_sticky", W'(nv_sticky_o), W'(0));
      repeat (2) begin
         @(negedge clk_i);
         conv_int_i = $urandom;
      end
      rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         check("post_rst_no_output", W'(out_valid_o), W'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
